// File: rtl/sram_dualport_arbiter_if.sv
// Client-side and SRAM-side bus of sram_dualport_arbiter, grouped so the
// arbiter and its environment share one declaration.
interface sram_dualport_arbiter_if #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int NUM_REQ = 4
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Handshake: a client raises req with addr/data stable. The transfer
   // happens in the cycle its gnt bit is high (same-cycle grant), after
   // which it may drop or change the request. Reads complete later as a
   // one-cycle rd_vld strobe that cannot be back-pressured.
   logic [NUM_REQ-1:0]       rd_req_i;
   logic [NUM_REQ*AW-1:0]    rd_addr_i;
   logic [NUM_REQ-1:0]       rd_gnt_o;
   logic [NUM_REQ-1:0]       rd_vld_o;
   logic [WIDTH-1:0]         rd_data_o;

   logic [NUM_REQ-1:0]       wr_req_i;
   logic [NUM_REQ*AW-1:0]    wr_addr_i;
   logic [NUM_REQ*WIDTH-1:0] wr_data_i;
   logic [NUM_REQ-1:0]       wr_gnt_o;

   logic                     mem_wen_o;
   logic [AW-1:0]            mem_waddr_o;
   logic [WIDTH-1:0]         mem_wdata_o;
   logic                     mem_ren_o;
   logic [AW-1:0]            mem_raddr_o;
   logic [WIDTH-1:0]         mem_rdata_i;
   logic                     mem_vld_i;

   logic                     err_o;
   logic [IW-1:0]            dbg_rd_ptr;
   logic [IW-1:0]            dbg_wr_ptr;

   modport slave (
      input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
      input  mem_rdata_i, mem_vld_i,
      output rd_gnt_o, rd_vld_o, rd_data_o, wr_gnt_o,
      output mem_wen_o, mem_waddr_o, mem_wdata_o, mem_ren_o, mem_raddr_o,
      output err_o, dbg_rd_ptr, dbg_wr_ptr
   );

   modport master (
      output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
      output mem_rdata_i, mem_vld_i,
      input  rd_gnt_o, rd_vld_o, rd_data_o, wr_gnt_o,
      input  mem_wen_o, mem_waddr_o, mem_wdata_o, mem_ren_o, mem_raddr_o,
      input  err_o, dbg_rd_ptr, dbg_wr_ptr
   );
endinterface

// File: rtl/sram_dualport_arbiter.sv
// Round-robin sharing of one pipelined dual-port SRAM between NUM_REQ readers
// and NUM_REQ writers, with a tag pipeline steering read data to its owner.
module sram_dualport_arbiter #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 8,
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   sram_dualport_arbiter_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef struct packed {
      logic          hit;
      logic [IW-1:0] idx;
   } pick_t;

   // First requester at or after ptr, wrapping. idx is 0 when nobody asks.
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                     input logic [IW-1:0]      ptr);
      pick_t         p;
      logic [IW:0]   c;
      logic [IW-1:0] ci;
      p = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         c = {1'b0, ptr} + (IW+1)'(j);
         if (c >= (IW+1)'(NUM_REQ)) begin
            c = c - (IW+1)'(NUM_REQ);
         end
         ci = c[IW-1:0];
         if (!p.hit && req[ci]) begin
            p.hit = 1'b1;
            p.idx = ci;
         end
      end
      return p;
   endfunction

   function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] k);
      return (k == IW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
   endfunction

   logic [IW-1:0] rd_ptr;
   logic [IW-1:0] wr_ptr;
   pick_t         rd_pick;
   pick_t         wr_pick;

   logic [LATENCY-1:0]         tag_vld;
   logic [LATENCY-1:0][IW-1:0] tag_id;
   logic                       err_q;

   logic [NUM_REQ-1:0] rd_gnt;
   logic [NUM_REQ-1:0] wr_gnt;
   logic [AW-1:0]      raddr;
   logic [AW-1:0]      waddr;
   logic [WIDTH-1:0]   wdata;
   logic [NUM_REQ-1:0] rd_vld;

   assign rd_pick = rr_pick(bus.rd_req_i, rd_ptr);
   assign wr_pick = rr_pick(bus.wr_req_i, wr_ptr);

   // Pointers only move on a grant; an idle cycle leaves priority unchanged.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (rd_pick.hit) rd_ptr <= ptr_after(rd_pick.idx);
         if (wr_pick.hit) wr_ptr <= ptr_after(wr_pick.idx);
      end
   end

   always_comb begin
      rd_gnt = '0;
      raddr  = '0;
      if (rd_pick.hit) begin
         rd_gnt = NUM_REQ'(1) << rd_pick.idx;
         raddr  = bus.rd_addr_i[rd_pick.idx*AW +: AW];
      end
   end

   always_comb begin
      wr_gnt = '0;
      waddr  = '0;
      wdata  = '0;
      if (wr_pick.hit) begin
         wr_gnt = NUM_REQ'(1) << wr_pick.idx;
         waddr  = bus.wr_addr_i[wr_pick.idx*AW +: AW];
         wdata  = bus.wr_data_i[wr_pick.idx*WIDTH +: WIDTH];
      end
   end

   // Tags advance in lockstep with the SRAM read pipeline; there is no stall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld[0] <= rd_pick.hit;
         tag_id[0]  <= rd_pick.idx;
         for (int s = 1; s < LATENCY; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
      end
   end

   // Any disagreement between SRAM return and expected tag is latched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (bus.mem_vld_i != tag_vld[LATENCY-1]) begin
         err_q <= 1'b1;
      end
   end

   always_comb begin
      rd_vld = '0;
      if (bus.mem_vld_i) begin
         rd_vld = NUM_REQ'(1) << tag_id[LATENCY-1];
      end
   end

   assign bus.rd_gnt_o    = rd_gnt;
   assign bus.rd_vld_o    = rd_vld;
   assign bus.rd_data_o   = bus.mem_rdata_i;
   assign bus.wr_gnt_o    = wr_gnt;
   assign bus.mem_ren_o   = rd_pick.hit;
   assign bus.mem_raddr_o = raddr;
   assign bus.mem_wen_o   = wr_pick.hit;
   assign bus.mem_waddr_o = waddr;
   assign bus.mem_wdata_o = wdata;
   assign bus.err_o       = err_q;
   assign bus.dbg_rd_ptr  = rd_ptr;
   assign bus.dbg_wr_ptr  = wr_ptr;
endmodule

// File: tb/tb_sram_dualport_arbiter.sv
// Directed bench for sram_dualport_arbiter with a behavioural 5-cycle SRAM
// whose words reset to 0x10+addr.
module tb_sram_dualport_arbiter;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 8;
   localparam int NUM_REQ = 4;
   localparam int LATENCY = 5;
   localparam int AW      = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic force_vld = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   sram_dualport_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) bus ();

   sram_dualport_arbiter #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ), .LATENCY(LATENCY)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   // Behavioural SRAM: read captured at the issue edge, returned LATENCY cycles later.
   logic [WIDTH-1:0]   sram_mem [DEPTH];
   logic [LATENCY-1:0] sp_vld;
   logic [WIDTH-1:0]   sp_data [LATENCY];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) sram_mem[a] <= WIDTH'(8'h10 + a);
         sp_vld <= '0;
         for (int s = 0; s < LATENCY; s++) sp_data[s] <= '0;
      end else begin
         if (bus.mem_wen_o) sram_mem[bus.mem_waddr_o] <= bus.mem_wdata_o;
         sp_vld     <= {sp_vld[LATENCY-2:0], bus.mem_ren_o};
         sp_data[0] <= sram_mem[bus.mem_raddr_o];
         for (int s = 1; s < LATENCY; s++) sp_data[s] <= sp_data[s-1];
      end
   end

   assign bus.mem_vld_i   = sp_vld[LATENCY-1] | force_vld;
   assign bus.mem_rdata_i = sp_data[LATENCY-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_rd(input int c, input logic [AW-1:0] a);
      bus.rd_addr_i[c*AW +: AW] = a;
   endtask

   task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      bus.wr_addr_i[c*AW +: AW]       = a;
      bus.wr_data_i[c*WIDTH +: WIDTH] = d;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      bus.rd_req_i  = '0;
      bus.rd_addr_i = '0;
      bus.wr_req_i  = '0;
      bus.wr_addr_i = '0;
      bus.wr_data_i = '0;
      force_vld     = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      #1;
      check("rst_rd_gnt", bus.rd_gnt_o, 0);
      check("rst_wr_gnt", bus.wr_gnt_o, 0);
      check("rst_rd_vld", bus.rd_vld_o, 0);
      check("rst_ren", bus.mem_ren_o, 0);
      check("rst_wen", bus.mem_wen_o, 0);
      check("rst_raddr", bus.mem_raddr_o, 0);
      check("rst_wdata", bus.mem_wdata_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_rd_ptr", bus.dbg_rd_ptr, 0);
      check("rst_wr_ptr", bus.dbg_wr_ptr, 0);

      // Single client read: client 2, addr 3 -> 0x13 five cycles later.
      step();
      bus.rd_req_i = 4'b0100;
      set_rd(2, 3'd3);
      #1;
      check("single_gnt", bus.rd_gnt_o, 4'b0100);
      check("single_ren", bus.mem_ren_o, 1);
      check("single_raddr", bus.mem_raddr_o, 3);
      for (int c = 1; c <= LATENCY; c++) begin
         step();
         bus.rd_req_i = '0;
         #1;
         if (c < LATENCY) begin
            check("single_vld_early", bus.rd_vld_o, 0);
         end else begin
            check("single_vld", bus.rd_vld_o, 4'b0100);
            check("single_data", bus.rd_data_o, 8'h13);
         end
      end
      check("single_ptr", bus.dbg_rd_ptr, 3);

      // Fairness: all four request for 8 cycles; client c reads addr c+4.
      do_reset();
      for (int c = 0; c < NUM_REQ; c++) set_rd(c, AW'(c + 4));
      for (int i = 0; i < 13; i++) begin
         step();
         bus.rd_req_i = (i < 8) ? 4'b1111 : 4'b0000;
         #1;
         check("rr_gnt", bus.rd_gnt_o, (i < 8) ? (32'd1 << (i % 4)) : 32'd0);
         if (i >= LATENCY) begin
            check("rr_vld", bus.rd_vld_o, 32'd1 << ((i - LATENCY) % 4));
            check("rr_data", bus.rd_data_o, 32'h14 + ((i - LATENCY) % 4));
         end else begin
            check("rr_vld_early", bus.rd_vld_o, 0);
         end
      end
      check("rr_ptr", bus.dbg_rd_ptr, 0);

      // Wrap and skip: move pointer to 3, then clients 0 and 1 contend.
      step();
      bus.rd_req_i = 4'b0100;
      #1;
      check("wrap_pre_gnt", bus.rd_gnt_o, 4'b0100);
      step();
      bus.rd_req_i = 4'b0011;
      #1;
      check("wrap_gnt0", bus.rd_gnt_o, 4'b0001);
      step();
      #1;
      check("wrap_gnt1", bus.rd_gnt_o, 4'b0010);
      step();
      #1;
      check("wrap_gnt2", bus.rd_gnt_o, 4'b0001);
      step();
      bus.rd_req_i = '0;
      for (int i = 0; i < LATENCY + 1; i++) step();
      #1;
      check("wrap_err", bus.err_o, 0);

      // Concurrent write then read of addr 6.
      do_reset();
      step();
      bus.wr_req_i = 4'b0100;
      set_wr(2, 3'd6, 8'hA5);
      #1;
      check("cw_wr_gnt", bus.wr_gnt_o, 4'b0100);
      check("cw_wen", bus.mem_wen_o, 1);
      check("cw_waddr", bus.mem_waddr_o, 6);
      check("cw_wdata", bus.mem_wdata_o, 8'hA5);
      check("cw_ren_idle", bus.mem_ren_o, 0);
      step();
      bus.wr_req_i = '0;
      bus.rd_req_i = 4'b0010;
      set_rd(1, 3'd6);
      #1;
      check("cw_rd_gnt", bus.rd_gnt_o, 4'b0010);
      check("cw_raddr", bus.mem_raddr_o, 6);
      check("cw_wen_idle", bus.mem_wen_o, 0);
      for (int c = 1; c <= LATENCY; c++) begin
         step();
         bus.rd_req_i = '0;
      end
      #1;
      check("cw_rd_vld", bus.rd_vld_o, 4'b0010);
      check("cw_rd_data", bus.rd_data_o, 8'hA5);
      check("cw_err", bus.err_o, 0);

      // Write pointer sits at 3 after the client-2 grant.
      step();
      bus.wr_req_i = 4'b1111;
      set_wr(0, 3'd0, 8'h30);
      set_wr(1, 3'd1, 8'h31);
      set_wr(2, 3'd2, 8'h32);
      set_wr(3, 3'd3, 8'h33);
      #1;
      check("wrr_gnt0", bus.wr_gnt_o, 4'b1000);
      check("wrr_waddr0", bus.mem_waddr_o, 3);
      check("wrr_wdata0", bus.mem_wdata_o, 8'h33);
      step();
      #1;
      check("wrr_gnt1", bus.wr_gnt_o, 4'b0001);
      check("wrr_wdata1", bus.mem_wdata_o, 8'h30);
      step();
      bus.wr_req_i = '0;
      #1;
      check("wrr_ptr", bus.dbg_wr_ptr, 1);
      check("wrr_rd_ptr", bus.dbg_rd_ptr, 2);

      // Protocol error: SRAM return with no read in flight.
      do_reset();
      step();
      force_vld = 1'b1;
      #1;
      check("err_before", bus.err_o, 0);
      check("err_vld_follows", bus.rd_vld_o, 4'b0001);
      step();
      force_vld = 1'b0;
      #1;
      check("err_set", bus.err_o, 1);
      step();
      step();
      #1;
      check("err_sticky", bus.err_o, 1);
      rst = 1'b1;
      #1;
      check("err_cleared", bus.err_o, 0);
      step();
      rst = 1'b0;

      // Reset mid-flight: three reads, reset, nothing returns, then a fresh read.
      do_reset();
      for (int c = 0; c < NUM_REQ; c++) set_rd(c, AW'(c));
      for (int i = 0; i < 3; i++) begin
         step();
         bus.rd_req_i = NUM_REQ'(1) << i;
         #1;
         check("mf_gnt", bus.rd_gnt_o, 32'd1 << i);
      end
      step();
      bus.rd_req_i = '0;
      step();
      rst = 1'b1;
      #1;
      check("mf_ptr", bus.dbg_rd_ptr, 0);
      check("mf_err", bus.err_o, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("mf_no_vld", bus.rd_vld_o, 0);
         step();
      end
      bus.rd_req_i = 4'b0010;
      set_rd(1, 3'd2);
      #1;
      check("mf_new_gnt", bus.rd_gnt_o, 4'b0010);
      for (int c = 1; c <= LATENCY; c++) begin
         step();
         bus.rd_req_i = '0;
         #1;
         if (c < LATENCY) begin
            check("mf_new_early", bus.rd_vld_o, 0);
         end else begin
            check("mf_new_vld", bus.rd_vld_o, 4'b0010);
            check("mf_new_data", bus.rd_data_o, 8'h12);
         end
      end
      check("mf_final_err", bus.err_o, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
